// File: rtl/gxb_bringup_seq.sv
// Transceiver bring-up sequencer: PLL power-down, filtered lock, offset-cancellation calibration,
// GXB power-up and staggered core reset release, with lock-loss recovery, timeouts and re-init.
module gxb_bringup_seq #(
   parameter int unsigned NUM_CH    = 1,
   parameter int unsigned PDOWN_CYC = 1000,
   parameter int unsigned LOCK_FILT = 5000,
   parameter int unsigned TIMEOUT   = 5000000,
   parameter int unsigned STAGGER   = 16,
   parameter int unsigned DEB_CYC   = 500000,
   parameter int unsigned CNT_W     = 8
) (
   input  logic              i_free_50MHz,
   input  logic              i_pcie_rstn,
   input  logic              i_pll_locked,
   input  logic              i_reconfig_busy,
   input  logic              i_btn_reinit_n,
   output logic              o_pll_areset,
   output logic              o_cal_rst,
   output logic              o_gxb_powerdown,
   output logic [NUM_CH-1:0] o_core_rstn,
   output logic              o_fault,
   output logic [1:0]        o_fault_code,
   output logic [CNT_W-1:0]  o_relock_cnt,
   output logic [3:0]        o_leds
);

   localparam int unsigned RelMax = PDOWN_CYC + NUM_CH * STAGGER;
   localparam int unsigned Max1   = (TIMEOUT > DEB_CYC) ? TIMEOUT : DEB_CYC;
   localparam int unsigned Max2   = (Max1 > RelMax) ? Max1 : RelMax;
   localparam int unsigned MaxCyc = (Max2 > LOCK_FILT) ? Max2 : LOCK_FILT;
   localparam int unsigned CW     = $clog2(MaxCyc + 1);

   localparam logic [CW-1:0] PdownLast = CW'(PDOWN_CYC - 1);
   localparam logic [CW-1:0] FiltLast  = CW'(LOCK_FILT - 1);
   localparam logic [CW-1:0] ToLast    = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] DebLast   = CW'(DEB_CYC - 1);
   localparam logic [CW-1:0] RelLast   = CW'(PDOWN_CYC + (NUM_CH - 1) * STAGGER);

   typedef enum logic [2:0] {
      StPdown, StWaitLock, StCalStart, StCalEnd, StGxbUp, StRun, StFault
   } state_e;

   logic [1:0]        r_rst_sync, r_lock_sync, r_busy_sync, r_btn_sync;
   logic              w_rst_n, w_lock, w_busy, w_btn;
   logic              r_btn_deb, w_press;
   logic [CW-1:0]     r_deb_cnt;
   state_e            r_state, w_state_d;
   logic [CW-1:0]     r_cnt, w_cnt_d, r_filt, w_filt_d;
   logic [1:0]        r_fault_code, w_code_d;
   logic              w_relock_inc, w_restart;
   logic              r_pll_areset, w_pll_d, r_cal_rst, w_cal_d, r_gxb_pd, w_gxb_d, r_fault;
   logic [NUM_CH-1:0] r_core_rstn, w_core_d;
   logic [CNT_W-1:0]  r_relock;

   // Reset asserts asynchronously, releases two clocks after pcie_rstn rises
   always_ff @(posedge i_free_50MHz or negedge i_pcie_rstn) begin
      if (!i_pcie_rstn) r_rst_sync <= 2'b00;
      else              r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   always_ff @(posedge i_free_50MHz or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_lock_sync <= 2'b00;
         r_busy_sync <= 2'b00;
         r_btn_sync  <= 2'b11;
         r_btn_deb   <= 1'b1;
         r_deb_cnt   <= '0;
      end else begin
         r_lock_sync <= {r_lock_sync[0], i_pll_locked};
         r_busy_sync <= {r_busy_sync[0], i_reconfig_busy};
         r_btn_sync  <= {r_btn_sync[0], i_btn_reinit_n};
         if (w_btn == r_btn_deb) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt == DebLast) begin
            r_btn_deb <= w_btn;
            r_deb_cnt <= '0;
         end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
         end
      end
   end

   assign w_lock  = r_lock_sync[1];
   assign w_busy  = r_busy_sync[1];
   assign w_btn   = r_btn_sync[1];
   // Press is the cycle the debounced level falls
   assign w_press = r_btn_deb && !w_btn && (r_deb_cnt == DebLast);

   always_comb begin
      w_state_d    = r_state;
      w_code_d     = r_fault_code;
      w_relock_inc = 1'b0;
      unique case (r_state)
         StPdown: if (r_cnt == PdownLast) w_state_d = StWaitLock;
         StWaitLock: begin
            if (w_lock && r_filt == FiltLast) begin
               w_state_d = StCalStart;
            end else if (r_cnt == ToLast) begin
               w_state_d = StFault;
               w_code_d  = 2'd1;
            end
         end
         StCalStart: begin
            if (!w_lock) begin
               w_state_d    = StPdown;
               w_relock_inc = 1'b1;
            end else if (w_busy) begin
               w_state_d = StCalEnd;
            end else if (r_cnt == ToLast) begin
               w_state_d = StFault;
               w_code_d  = 2'd2;
            end
         end
         StCalEnd: begin
            if (!w_lock) begin
               w_state_d    = StPdown;
               w_relock_inc = 1'b1;
            end else if (!w_busy) begin
               w_state_d = StGxbUp;
            end else if (r_cnt == ToLast) begin
               w_state_d = StFault;
               w_code_d  = 2'd3;
            end
         end
         StGxbUp: begin
            if (!w_lock) begin
               w_state_d    = StPdown;
               w_relock_inc = 1'b1;
            end else if (r_cnt == RelLast) begin
               w_state_d = StRun;
            end
         end
         StRun: begin
            if (!w_lock) begin
               w_state_d    = StPdown;
               w_relock_inc = 1'b1;
            end
         end
         StFault: ;
         default: w_state_d = StPdown;
      endcase
      // A re-init press overrides everything, including a simultaneous lock loss
      if (w_press) begin
         w_state_d    = StPdown;
         w_code_d     = 2'd0;
         w_relock_inc = 1'b0;
      end
      w_restart = w_press || (w_state_d != r_state);
      w_cnt_d   = w_restart ? '0 : ((r_cnt == '1) ? r_cnt : r_cnt + 1'b1);
      w_filt_d  = (!w_restart && r_state == StWaitLock && w_lock) ? r_filt + 1'b1 : '0;
   end

   always_comb begin
      w_pll_d  = 1'b1;
      w_cal_d  = 1'b1;
      w_gxb_d  = 1'b1;
      w_core_d = '0;
      unique case (w_state_d)
         StWaitLock: w_pll_d = 1'b0;
         StCalStart, StCalEnd: begin
            w_pll_d = 1'b0;
            w_cal_d = 1'b0;
         end
         StGxbUp: begin
            w_pll_d = 1'b0;
            w_cal_d = 1'b0;
            w_gxb_d = 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
               w_core_d[k] = (w_cnt_d >= CW'(PDOWN_CYC + k * STAGGER));
            end
         end
         StRun: begin
            w_pll_d  = 1'b0;
            w_cal_d  = 1'b0;
            w_gxb_d  = 1'b0;
            w_core_d = '1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_free_50MHz or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state      <= StPdown;
         r_cnt        <= '0;
         r_filt       <= '0;
         r_fault_code <= 2'd0;
         r_relock     <= '0;
         r_pll_areset <= 1'b1;
         r_cal_rst    <= 1'b1;
         r_gxb_pd     <= 1'b1;
         r_core_rstn  <= '0;
         r_fault      <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_cnt        <= w_cnt_d;
         r_filt       <= w_filt_d;
         r_fault_code <= w_code_d;
         r_pll_areset <= w_pll_d;
         r_cal_rst    <= w_cal_d;
         r_gxb_pd     <= w_gxb_d;
         r_core_rstn  <= w_core_d;
         r_fault      <= (w_state_d == StFault);
         if (w_relock_inc && r_relock != '1) r_relock <= r_relock + 1'b1;
      end
   end

   assign o_pll_areset    = r_pll_areset;
   assign o_cal_rst       = r_cal_rst;
   assign o_gxb_powerdown = r_gxb_pd;
   assign o_core_rstn     = r_core_rstn;
   assign o_fault         = r_fault;
   assign o_fault_code    = r_fault_code;
   assign o_relock_cnt    = r_relock;
   assign o_leds          = {r_fault, r_core_rstn[0], ~r_cal_rst, ~r_pll_areset};

endmodule

// File: tb/tb_gxb_bringup_seq.sv
// Bench for gxb_bringup_seq: expected event cycles are derived arithmetically from the
// randomized input schedule (two-flop input latency, phase lengths) and compared every cycle.
module tb_gxb_bringup_seq;

   localparam int NUM_CH = 2;
   localparam int PDOWN  = 4;
   localparam int FILT   = 8;
   localparam int TO     = 64;
   localparam int STAG   = 3;
   localparam int DEB    = 4;
   localparam int CNT_W  = 8;

   logic              clk  = 1'b0;
   logic              rstn = 1'b1;
   logic              lock = 1'b0;
   logic              busy = 1'b0;
   logic              btn  = 1'b1;
   logic              pll, cal, gxb, fault;
   logic [NUM_CH-1:0] core;
   logic [1:0]        fault_code;
   logic [CNT_W-1:0]  relock;
   logic [3:0]        leds;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_relock = 0;

   gxb_bringup_seq #(
      .NUM_CH(NUM_CH), .PDOWN_CYC(PDOWN), .LOCK_FILT(FILT), .TIMEOUT(TO),
      .STAGGER(STAG), .DEB_CYC(DEB), .CNT_W(CNT_W)
   ) dut (
      .i_free_50MHz(clk), .i_pcie_rstn(rstn), .i_pll_locked(lock), .i_reconfig_busy(busy),
      .i_btn_reinit_n(btn), .o_pll_areset(pll), .o_cal_rst(cal), .o_gxb_powerdown(gxb),
      .o_core_rstn(core), .o_fault(fault), .o_fault_code(fault_code), .o_relock_cnt(relock),
      .o_leds(leds)
   );

   always #5 clk = ~clk;

   function automatic int imax(int a, int b);
      return (a > b) ? a : b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Releases reset just after an edge; r0 is that edge's index.
   task automatic do_reset(output int r0);
      rstn = 1'b0; lock = 1'b0; busy = 1'b0; btn = 1'b1;
      repeat (4) tick();
      rstn = 1'b1;
      r0 = cyc;
      exp_relock = 0;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      rstn = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({pll, cal, gxb, core} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 11100", {pll, cal, gxb, core});
         end
         checks++;
         if ({fault, fault_code} !== 3'b000 || relock !== 8'd0) begin
            errors++;
            $display("FAIL reset_status: got fault=%b code=%0d relock=%0d want 0 0 0",
                     fault, fault_code, relock);
         end
         checks++;
         if (leds !== 4'b0000) begin
            errors++;
            $display("FAIL reset_leds: got %b want 0000", leds);
         end
         repeat (2) tick();
      end
   endtask

   task automatic test_nominal();
      int r0, ld, bd, bl, w, c, g;
      logic [4:0] exp_v;
      for (int it = 0; it < 3; it++) begin
         ld = (it == 0) ? 10 : int'($urandom_range(0, 20));
         bd = (it == 0) ? 0 : int'($urandom_range(0, 5));
         bl = (it == 0) ? 5 : int'($urandom_range(1, 6));
         do_reset(r0);
         w = r0 + 2 + PDOWN;
         c = imax(r0 + ld + 10, w + FILT);
         g = c + bd + bl + 3;
         while (cyc < g + 12) begin
            lock = (cyc >= r0 + ld);
            busy = (cyc >= c + bd) && (cyc < c + bd + bl);
            tick();
            exp_v = {cyc < w, cyc < c, cyc < g, cyc >= g + PDOWN + STAG, cyc >= g + PDOWN};
            checks++;
            if ({pll, cal, gxb, core} !== exp_v) begin
               errors++;
               $display("FAIL nominal it%0d t=%0d: {pll,cal,gxb,core} got %b want %b",
                        it, cyc - r0, {pll, cal, gxb, core}, exp_v);
            end
         end
         checks++;
         if (leds !== 4'b0111 || fault !== 1'b0 || relock !== 8'd0) begin
            errors++;
            $display("FAIL nominal_run it%0d: leds=%b fault=%b relock=%0d want 0111 0 0",
                     it, leds, fault, relock);
         end
      end
   endtask

   task automatic test_glitch();
      int r0, w, k, h, c;
      for (int it = 0; it < 3; it++) begin
         do_reset(r0);
         w = r0 + 2 + PDOWN;
         k = w + int'($urandom_range(0, 4));
         h = (it == 0) ? 6 : int'($urandom_range(1, FILT - 1));
         c = imax(k + h + 1 + 10, w + FILT);
         while (cyc < c + 3) begin
            lock = (cyc >= k) && (cyc != k + h);
            tick();
            checks++;
            if (cal !== (cyc < c)) begin
               errors++;
               $display("FAIL glitch it%0d h=%0d t=%0d: cal_rst got %b want %b",
                        it, h, cyc - r0, cal, cyc < c);
            end
         end
      end
   endtask

   task automatic test_timeouts();
      int r0, w, c, d, b;
      // Lock never rises
      do_reset(r0);
      w = r0 + 2 + PDOWN;
      while (cyc < w + TO + 2) begin
         tick();
         checks++;
         if (fault !== (cyc >= w + TO)) begin
            errors++;
            $display("FAIL lock_timeout t=%0d: fault got %b want %b", cyc - w, fault, cyc >= w + TO);
         end
      end
      checks++;
      if (fault_code !== 2'd1 || leds !== 4'b1000 || {pll, gxb, core} !== 4'b1100) begin
         errors++;
         $display("FAIL lock_timeout_state: code=%0d leds=%b pll/gxb/core=%b want 1 1000 1100",
                  fault_code, leds, {pll, gxb, core});
      end
      // Short bounces must be ignored
      for (int j = 0; j < 4; j++) begin
         btn = 1'b0;
         repeat ($urandom_range(1, DEB - 1)) tick();
         btn = 1'b1;
         repeat ($urandom_range(1, 3)) tick();
         checks++;
         if (fault !== 1'b1) begin
            errors++;
            $display("FAIL bounce %0d: fault got %b want 1", j, fault);
         end
      end
      repeat (4) tick();
      checks++;
      if (fault !== 1'b1 || fault_code !== 2'd1) begin
         errors++;
         $display("FAIL bounce_end: fault=%b code=%0d want 1 1", fault, fault_code);
      end
      // Clean press exits FAULT into PDOWN
      b = cyc;
      btn = 1'b0;
      while (cyc < b + 14) begin
         tick();
         checks++;
         if ({fault, fault_code, pll} !== {cyc < b + 6, (cyc < b + 6) ? 2'd1 : 2'd0, cyc < b + 10}) begin
            errors++;
            $display("FAIL press_fault t=%0d: {fault,code,pll} got %b want %b", cyc - b,
                     {fault, fault_code, pll},
                     {cyc < b + 6, (cyc < b + 6) ? 2'd1 : 2'd0, cyc < b + 10});
         end
      end
      btn = 1'b1;
      repeat (8) tick();
      // Busy never rises, then busy never falls
      for (int m = 0; m < 2; m++) begin
         do_reset(r0);
         lock = 1'b1;
         c = r0 + 2 + PDOWN + FILT;
         d = c + 3;
         while (cyc < ((m == 0) ? c : d) + TO + 2) begin
            busy = (m == 1) && (cyc >= c);
            tick();
            checks++;
            if (fault !== (cyc >= ((m == 0) ? c : d) + TO)) begin
               errors++;
               $display("FAIL cal_timeout%0d t=%0d: fault got %b want %b", m, cyc - r0, fault,
                        cyc >= ((m == 0) ? c : d) + TO);
            end
         end
         checks++;
         if (fault_code !== 2'(m + 2)) begin
            errors++;
            $display("FAIL cal_timeout%0d_code: got %0d want %0d", m, fault_code, m + 2);
         end
         busy = 1'b0;
      end
   endtask

   task automatic test_lock_loss();
      int r0, c, g, x, cp, gp;
      logic in_seq;
      logic [4:0] exp_v;
      do_reset(r0);
      lock = 1'b1;
      c = r0 + 2 + PDOWN + FILT;
      g = c + 5;
      while (cyc < g + 10) begin
         busy = (cyc >= c) && (cyc < c + 2);
         tick();
      end
      x  = cyc;
      cp = x + 3 + PDOWN + FILT;
      gp = cp + 6;
      while (cyc < gp + 10) begin
         lock = (cyc != x);
         busy = (cyc >= cp + 1) && (cyc < cp + 3);
         tick();
         in_seq = (cyc >= x + 3);
         exp_v = {in_seq && cyc < x + 3 + PDOWN, in_seq && cyc < cp, in_seq && cyc < gp,
                  !in_seq || cyc >= gp + PDOWN + STAG, !in_seq || cyc >= gp + PDOWN};
         checks++;
         if ({pll, cal, gxb, core} !== exp_v || relock !== (in_seq ? 8'd1 : 8'd0)) begin
            errors++;
            $display("FAIL lock_loss t=%0d: {pll,cal,gxb,core}=%b relock=%0d want %b %0d",
                     cyc - x, {pll, cal, gxb, core}, relock, exp_v, in_seq ? 1 : 0);
         end
      end
      exp_relock = 1;
   endtask

   task automatic test_press_vs_loss();
      int b;
      b = cyc;
      btn = 1'b0;
      while (cyc < b + 10) begin
         lock = (cyc != b + 3);
         tick();
         checks++;
         if (core !== ((cyc < b + 6) ? 2'b11 : 2'b00) || relock !== 8'(exp_relock) ||
             pll !== (cyc >= b + 6 && cyc < b + 10)) begin
            errors++;
            $display("FAIL press_vs_loss t=%0d: core=%b relock=%0d pll=%b want %b %0d %b",
                     cyc - b, core, relock, pll, (cyc < b + 6) ? 2'b11 : 2'b00, exp_relock,
                     cyc >= b + 6 && cyc < b + 10);
         end
      end
      btn = 1'b1;
      lock = 1'b1;
      repeat (10) tick();
   endtask

   task automatic test_saturation();
      bit ok;
      for (int n = 0; n < 256; n++) begin
         ok = 1'b0;
         for (int t = 0; t < 100 && !ok; t++) begin
            tick();
            ok = (cal === 1'b0);
         end
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL sat_wait %0d: cal_rst got %b want 0 within 100 cycles", n, cal);
            break;
         end
         lock = 1'b0;
         tick();
         lock = 1'b1;
         tick();
         tick();
         exp_relock = (exp_relock < 255) ? exp_relock + 1 : 255;
         checks++;
         if (relock !== 8'(exp_relock)) begin
            errors++;
            $display("FAIL relock_sat %0d: got %0d want %0d", n, relock, exp_relock);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
         tick();
         ok = (cal === 1'b0);
      end
      busy = 1'b1;
      tick();
      tick();
      busy = 1'b0;
      for (int t = 0; t < 50 && ok; t++) begin
         tick();
         if (gxb === 1'b0) break;
      end
      repeat (PDOWN + 1) tick();
      checks++;
      if (core !== 2'b01 || gxb !== 1'b0 || relock !== 8'd255) begin
         errors++;
         $display("FAIL mid_gxb_up: core=%b gxb=%b relock=%0d want 01 0 255", core, gxb, relock);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if ({pll, cal, gxb, core} !== 5'b11100 || relock !== 8'd0 || leds !== 4'b0000 ||
          {fault, fault_code} !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset: outs=%b relock=%0d leds=%b fault=%b code=%0d want 11100 0 0000 0 0",
                  {pll, cal, gxb, core}, relock, leds, fault, fault_code);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_glitch();
      test_timeouts();
      test_lock_loss();
      test_press_vs_loss();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
